// File: rtl/riscv_trace_gen_pkg.sv
// Shared definitions for the dual-core commit-trace producer.
// Record field widths, drop counter width and the buffered record layout.
// Optional RISCV_TRACE_TS_EN adds a capture timestamp to every record.
package riscv_trace_gen_pkg;

    localparam int TRACE_PC_W   = 32;
    localparam int TRACE_OP_W   = 32;
    localparam int TRACE_TS_W   = 32;
    localparam int TRACE_DROP_W = 16;

    // One buffered commit record; 96 bits with timestamp, 64 without.
    typedef struct packed {
`ifdef RISCV_TRACE_TS_EN
        logic [TRACE_TS_W-1:0] ts;
`endif
        logic [TRACE_PC_W-1:0] pc;
        logic [TRACE_OP_W-1:0] opcode;
    } rec_t;

endpackage

// File: rtl/riscv_trace_gen_if.sv
// Bundle of both core commit ports and the merged valid/ready trace stream.
// master = trace producer (consumes commits, drives the trace stream).
// trace_ts exists only when RISCV_TRACE_TS_EN is defined.
interface riscv_trace_gen_if;
    import riscv_trace_gen_pkg::*;

    logic                  core0_valid;
    logic [TRACE_PC_W-1:0] core0_pc;
    logic [TRACE_OP_W-1:0] core0_opcode;
    logic                  core1_valid;
    logic [TRACE_PC_W-1:0] core1_pc;
    logic [TRACE_OP_W-1:0] core1_opcode;

    logic                  trace_valid;
    logic                  trace_ready;
    logic                  trace_core;
    logic [TRACE_PC_W-1:0] trace_pc;
    logic [TRACE_OP_W-1:0] trace_opcode;
`ifdef RISCV_TRACE_TS_EN
    logic [TRACE_TS_W-1:0] trace_ts;
`endif

    modport master (
`ifdef RISCV_TRACE_TS_EN
        output trace_ts,
`endif
        input  core0_valid, core0_pc, core0_opcode,
        input  core1_valid, core1_pc, core1_opcode,
        input  trace_ready,
        output trace_valid, trace_core, trace_pc, trace_opcode
    );

    modport slave (
`ifdef RISCV_TRACE_TS_EN
        input  trace_ts,
`endif
        output core0_valid, core0_pc, core0_opcode,
        output core1_valid, core1_pc, core1_opcode,
        output trace_ready,
        input  trace_valid, trace_core, trace_pc, trace_opcode
    );

endinterface

// File: rtl/riscv_trace_fifo.sv
// Per-core record buffer: DEPTH entries of W bits, pointer-wrap full/empty.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: none internally; caller must not push when full or pop when empty.
module riscv_trace_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra MSB distinguishes a full buffer from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only read behind a valid pointer.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/riscv_trace_gen.sv
// Dual-core commit trace: per-core FIFOs merged round-robin into one output register.
// Latency: record captured at edge E appears on trace_valid after edge E+1 (earliest).
// Backpressure: trace_ready stalls the output register; cores are never stalled, overflow is counted.
// Optional feature macro: RISCV_TRACE_TS_EN (32-bit capture timestamp per record).
module riscv_trace_gen
    import riscv_trace_gen_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    riscv_trace_gen_if.master       bus,
    output logic [TRACE_DROP_W-1:0] drop0_o,
    output logic [TRACE_DROP_W-1:0] drop1_o
);
    localparam int RW = $bits(rec_t);

    rec_t in0, in1, head0, head1;
    logic full0, empty0, full1, empty1;
    logic push0, push1, pop0, pop1;
    logic can_load, gnt_vld, gnt;
    logic rr_q;

    logic out_vld;
    logic out_core;
    rec_t out_rec;

`ifdef RISCV_TRACE_TS_EN
    logic [TRACE_TS_W-1:0] ts_q;

    // Free-running cycle counter sampled into each captured record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + 1'b1;
    end

    assign in0 = '{ts: ts_q, pc: bus.core0_pc, opcode: bus.core0_opcode};
    assign in1 = '{ts: ts_q, pc: bus.core1_pc, opcode: bus.core1_opcode};
    assign bus.trace_ts = out_rec.ts;
`else
    assign in0 = '{pc: bus.core0_pc, opcode: bus.core0_opcode};
    assign in1 = '{pc: bus.core1_pc, opcode: bus.core1_opcode};
`endif

    // Fullness is the pre-edge state, so a same-edge pop never rescues a push.
    assign push0 = bus.core0_valid & enable_i & ~full0;
    assign push1 = bus.core1_valid & enable_i & ~full1;

    riscv_trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo0 (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push0),
        .push_dat (in0),
        .pop      (pop0),
        .pop_dat  (head0),
        .full     (full0),
        .empty    (empty0)
    );

    riscv_trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo1 (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push1),
        .push_dat (in1),
        .pop      (pop1),
        .pop_dat  (head1),
        .full     (full1),
        .empty    (empty1)
    );

    // Round-robin grant: rr_q breaks ties, a lone non-empty FIFO always wins.
    always_comb begin
        can_load = ~out_vld | bus.trace_ready;
        gnt_vld  = ~empty0 | ~empty1;
        gnt      = (~empty0 & ~empty1) ? rr_q : empty0;
        pop0     = can_load & gnt_vld & ~gnt;
        pop1     = can_load & gnt_vld & gnt;
    end

    // Output register and priority pointer; holds every bit while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld  <= 1'b0;
            out_core <= 1'b0;
            out_rec  <= '0;
            rr_q     <= 1'b0;
        end else if (can_load) begin
            out_vld <= gnt_vld;
            if (gnt_vld) begin
                out_core <= gnt;
                out_rec  <= gnt ? head1 : head0;
                rr_q     <= ~gnt;
            end
        end
    end

    // Saturating per-core drop counters; only enabled commits can drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop0_o <= '0;
            drop1_o <= '0;
        end else begin
            if (bus.core0_valid & enable_i & full0 & (drop0_o != '1))
                drop0_o <= drop0_o + 1'b1;
            if (bus.core1_valid & enable_i & full1 & (drop1_o != '1))
                drop1_o <= drop1_o + 1'b1;
        end
    end

    assign bus.trace_valid  = out_vld;
    assign bus.trace_core   = out_core;
    assign bus.trace_pc     = out_rec.pc;
    assign bus.trace_opcode = out_rec.opcode;

endmodule
